// File: rtl/activation_pipe.sv
// Two-stage activation pipeline: per-channel arithmetic scale, pass/ReLU/leaky activation,
// saturation to OUT_W bits, valid/ready flow control and a sticky saturation event counter.
module activation_pipe #(
    parameter int N_CH    = 4,
    parameter int IN_W    = 12,
    parameter int OUT_W   = 5,
    parameter int SHIFT   = 3,
    parameter int LEAK_SH = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N_CH*IN_W-1:0]    in_data_i,
    input  logic [1:0]              in_mode_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [N_CH*OUT_W-1:0]   out_data_o,
    output logic                    out_sat_o,
    input  logic                    sat_clr_i,
    output logic [CNT_W-1:0]        sat_cnt_o
);

    localparam int S_W = IN_W - SHIFT;

    logic                    s1_valid_q;
    logic [N_CH*S_W-1:0]     s1_data_q, s1_data_d;
    logic [1:0]              s1_mode_q;
    logic                    s2_valid_q;
    logic [N_CH*OUT_W-1:0]   out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;
    logic [N_CH-1:0][OUT_W:0] act_res;
    logic [N_CH*SHIFT-1:0]   unused_lsbs;

    logic s1_en, s2_en, out_xfer;

    assign s2_en      = !s2_valid_q || out_ready_i;
    assign s1_en      = !s1_valid_q || s2_en;
    assign in_ready_o = s1_en && rst_n_i;
    assign out_xfer   = s2_valid_q && out_ready_i;

    // {sat, value}: activation on the scaled sample, then clamp to the OUT_W signed range
    function automatic logic [OUT_W:0] act_sat(input logic [S_W-1:0] s, input logic [1:0] mode);
        logic [S_W-1:0]   y;
        logic             ovf;
        logic [OUT_W-1:0] q;
        y = s;
        case (mode)
            2'b00: y = s;
            2'b10: begin
                if (s[S_W-1]) y = $signed(s) >>> LEAK_SH;
                else          y = s;
            end
            default: begin
                if (s[S_W-1]) y = '0;
                else          y = s;
            end
        endcase
        ovf = (y[S_W-1:OUT_W-1] != {(S_W-OUT_W+1){y[S_W-1]}});
        if (ovf) q = y[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else     q = y[OUT_W-1:0];
        return {ovf, q};
    endfunction

    // Dropping the low SHIFT bits is exactly a flooring arithmetic shift.
    always_comb begin
        s1_data_d   = '0;
        unused_lsbs = '0;
        for (int c = 0; c < N_CH; c++) begin
            s1_data_d[c*S_W +: S_W]     = in_data_i[c*IN_W+SHIFT +: S_W];
            unused_lsbs[c*SHIFT +: SHIFT] = in_data_i[c*IN_W +: SHIFT];
        end
    end

    always_comb begin
        act_res    = '0;
        out_data_d = '0;
        out_sat_d  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            act_res[c] = act_sat(s1_data_q[c*S_W +: S_W], s1_mode_q);
            out_data_d[c*OUT_W +: OUT_W] = act_res[c][OUT_W-1:0];
            out_sat_d = out_sat_d | act_res[c][OUT_W];
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i)
            sat_cnt_d = '0;
        else if (out_xfer && out_sat_q && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 2'b00;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            if (s1_en)
                s1_valid_q <= in_valid_i;
            if (s1_en && in_valid_i) begin
                s1_data_q <= s1_data_d;
                s1_mode_q <= in_mode_i;
            end
            if (s2_en)
                s2_valid_q <= s1_valid_q;
            if (s2_en && s1_valid_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
    assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe: vector table for the activation math, plus
// hand-written sequences for backpressure, counter saturation/clear and async reset.
module tb_activation_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] in_data = '0;
    logic [1:0]  in_mode = 2'b00;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic        in_ready, out_valid, out_sat;
    logic [19:0] out_data;
    logic [15:0] sat_cnt;
    logic        in_ready2, out_valid2, out_sat2;
    logic [19:0] out_data2;
    logic [1:0]  sat_cnt2;

    always #5 clk = ~clk;

    activation_pipe #(.N_CH(4), .IN_W(12), .OUT_W(5), .SHIFT(3), .LEAK_SH(2), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_mode_i(in_mode), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_sat_o(out_sat),
        .sat_clr_i(sat_clr), .sat_cnt_o(sat_cnt)
    );

    activation_pipe #(.N_CH(4), .IN_W(12), .OUT_W(5), .SHIFT(3), .LEAK_SH(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_data_i(in_data), .in_mode_i(in_mode), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_data_o(out_data2), .out_sat_o(out_sat2),
        .sat_clr_i(sat_clr), .sat_cnt_o(sat_cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk_in(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic logic [19:0] pk_out(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [47:0] t4_in(input int i);
        return pk_in((i-3)*8, (i-2)*8, (i-1)*8, i*8);
    endfunction

    function automatic logic [19:0] t4_out(input int i);
        return pk_out(i-3, i-2, i-1, i);
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [47:0] din;
        logic [19:0] dout;
        logic        sat;
    } vec_t;

    vec_t        vecs[10];
    logic        cap_valid, cap_sat;
    logic [19:0] cap_data;

    // Present one beat, capture the output one edge after acceptance, then let it transfer.
    task automatic run_beat(input logic [1:0] m, input logic [47:0] d, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        @(posedge clk); #1;
        cap_valid = out_valid; cap_data = out_data; cap_sat = out_sat;
        sat_clr = clr;
        @(posedge clk); #1;
        sat_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        int sent, recv;
        logic stall_prev;
        logic [19:0] held;

        vecs[0] = '{2'b01, pk_in(120, 200, -50, 7),      pk_out(15, 15, 0, 0),     1'b1};
        vecs[1] = '{2'b10, pk_in(-64, -1, -8, 40),       pk_out(-2, -1, -1, 5),    1'b0};
        vecs[2] = '{2'b00, pk_in(-200, 127, -128, 0),    pk_out(-16, 15, -16, 0),  1'b1};
        vecs[3] = '{2'b00, pk_in(2047, -2048, 8, -8),    pk_out(15, -16, 1, -1),   1'b1};
        vecs[4] = '{2'b01, pk_in(2047, -2048, -1, 0),    pk_out(15, 0, 0, 0),      1'b1};
        vecs[5] = '{2'b01, pk_in(-2048, -2048, -2048, -2048), pk_out(0, 0, 0, 0),  1'b0};
        vecs[6] = '{2'b10, pk_in(-2048, 2047, 0, -9),    pk_out(-16, 15, 0, -1),   1'b1};
        vecs[7] = '{2'b11, pk_in(8, -8, 16, -200),       pk_out(1, 0, 2, 0),       1'b0};
        vecs[8] = '{2'b00, pk_in(8, -8, -1, 0),          pk_out(1, -1, -1, 0),     1'b0};
        vecs[9] = '{2'b10, pk_in(-127, -32, 120, -128),  pk_out(-4, -1, 15, -4),   1'b0};

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 20'h0);
        check("rst_out_sat", out_sat, 1'b0);
        check("rst_sat_cnt", sat_cnt, 16'h0);
        do_reset();

        // Activation table
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_beat(vecs[i].mode, vecs[i].din, 1'b0);
            if (vecs[i].sat) exp_cnt++;
            check($sformatf("vec%0d_valid", i), cap_valid, 1'b1);
            check($sformatf("vec%0d_data", i), cap_data, vecs[i].dout);
            check($sformatf("vec%0d_sat", i), cap_sat, vecs[i].sat);
            check($sformatf("vec%0d_cnt", i), sat_cnt, 64'(exp_cnt));
            check($sformatf("vec%0d_cnt2", i), sat_cnt2, 64'((exp_cnt > 3) ? 3 : exp_cnt));
        end

        // Streaming with out_ready pattern 1,0,0
        sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 8);
            in_mode   = 2'b00;
            in_data   = (sent < 8) ? t4_in(sent) : '0;
            #1;
            check("t4_in_ready", in_ready, !((sent - recv) == 2 && !out_ready));
            if (stall_prev) begin
                check("t4_hold_valid", out_valid, 1'b1);
                check("t4_hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                check($sformatf("t4_beat%0d", recv), out_data, t4_out(recv));
                recv++;
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4_all_received", 64'(recv), 64'd8);

        // Counter: count, clear priority, saturation at all-ones
        do_reset();
        for (int i = 0; i < 3; i++) run_beat(2'b00, pk_in(2047, 0, 0, 0), 1'b0);
        check("t5_cnt3", sat_cnt, 16'd3);
        check("t5_cnt3_w2", sat_cnt2, 2'd3);
        run_beat(2'b00, pk_in(2047, 0, 0, 0), 1'b1);
        check("t5_clr_sat", cap_sat, 1'b1);
        check("t5_clr", sat_cnt, 16'd0);
        check("t5_clr_w2", sat_cnt2, 2'd0);
        for (int i = 0; i < 4; i++) run_beat(2'b00, pk_in(0, -2048, 0, 0), 1'b0);
        check("t5_cnt4", sat_cnt, 16'd4);
        check("t5_hold_w2", sat_cnt2, 2'd3);

        // Async reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_data = t4_in(1);
        @(posedge clk); #1;
        in_data = t4_in(2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_full_in_ready", in_ready, 1'b0);
        check("t6_full_valid", out_valid, 1'b1);
        check("t6_full_data", out_data, t4_out(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_data", out_data, 20'h0);
        check("t6_rst_sat", out_sat, 1'b0);
        check("t6_rst_cnt", sat_cnt, 16'h0);
        check("t6_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = t4_in(5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_lat1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("t6_lat2_valid", out_valid, 1'b1);
        check("t6_lat2_data", out_data, t4_out(5));
        @(posedge clk); #1;
        check("t6_no_dup", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
